// File: rtl/cbus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter_pkg
// Description : CBus request/response types and helpers shared by the
//               round-robin arbiter and its sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_rr_arbiter_pkg;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;
    localparam int CBUS_LEN_W  = 8;

    typedef struct packed {
        logic                     valid;
        logic                     write;
        logic [CBUS_ADDR_W-1:0]   addr;
        logic [2:0]               size;
        logic [CBUS_LEN_W-1:0]    len;
        logic [CBUS_DATA_W/8-1:0] strobe;
        logic [CBUS_DATA_W-1:0]   data;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    // Increment an index modulo n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter_rr_pick
// Description : Combinational rotating-priority search: first valid,
//               non-excluded index at or after start_i, wrapping at N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic [N-1:0]     excl_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0] w_cand;
    int           w_pos;

    assign w_cand = valid_i & ~excl_i;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(start_i) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!hit_o && w_cand[IDX_W'(w_pos)]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter
// Description : Round-robin arbiter sharing one downstream CBus port between
//               NUM_INPUTS masters; ownership lasts a whole transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_idx
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NUM_INPUTS-1:0]   w_valid;
    logic [NUM_INPUTS-1:0]   w_excl;
    logic [IDX_W-1:0]        w_owner_inc;
    logic [IDX_W-1:0]        w_idle_idx;
    logic [IDX_W-1:0]        w_rel_idx;
    logic                    w_idle_hit;
    logic                    w_rel_hit;
    logic                    w_release;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
        assign w_valid[gi] = ireqs[gi].valid;
    end

    assign w_owner_inc = IDX_W'(rr_wrap_inc(int'(owner_q), NUM_INPUTS));
    assign w_release   = (state_q == ST_OWNED) && oresp.ready && oresp.last;

    // The finishing master still shows valid in its last beat; mask it out.
    always_comb begin
        w_excl          = '0;
        w_excl[owner_q] = 1'b1;
    end

    cbus_rr_arbiter_rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick_idle (
        .valid_i (w_valid),
        .start_i (rr_ptr_q),
        .excl_i  ('0),
        .hit_o   (w_idle_hit),
        .idx_o   (w_idle_idx)
    );

    cbus_rr_arbiter_rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick_release (
        .valid_i (w_valid),
        .start_i (w_owner_inc),
        .excl_i  (w_excl),
        .hit_o   (w_rel_hit),
        .idx_o   (w_rel_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_idle_hit) begin
                    owner_d = w_idle_idx;
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (w_release) begin
                    rr_ptr_d = w_owner_inc;
                    if (w_rel_hit) begin
                        owner_d = w_rel_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request and response paths are pure muxes: no register stage on data.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == ST_OWNED) begin
            oreq            = ireqs[owner_q];
            iresps[owner_q] = oresp;
        end
    end

    assign busy      = (state_q == ST_OWNED);
    assign grant_idx = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_rr_arbiter
// Description : Self-checking bench for cbus_rr_arbiter (2- and 3-input).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [0:0]           gidx;

    cbus_req_t  [2:0]     ireqs3;
    cbus_resp_t [2:0]     iresps3;
    cbus_req_t            oreq3;
    cbus_resp_t           oresp3;
    logic                 busy3;
    logic [1:0]           gidx3;

    int checks = 0;
    int errors = 0;

    cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (gidx)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs3),
        .iresps    (iresps3),
        .oreq      (oreq3),
        .oresp     (oresp3),
        .busy      (busy3),
        .grant_idx (gidx3)
    );

    always #5 clk = ~clk;

    function automatic cbus_req_t rand_req(input int len);
        cbus_req_t r;
        r.valid  = 1'b1;
        r.write  = 1'($urandom_range(0, 1));
        r.addr   = $urandom;
        r.size   = 3'($urandom_range(0, 2));
        r.len    = 8'(len);
        r.strobe = 4'($urandom);
        r.data   = $urandom;
        return r;
    endfunction

    // First valid index at or after start (mod N), skipping excl; -1 if none.
    function automatic int find_from(input bit vv[N], input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (j != excl && vv[j]) return j;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireqs  = '0;
        ireqs3 = '0;
        oresp  = '0;
        oresp3 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || gidx !== 1'b0 || oreq !== cbus_req_t'(0) || iresps !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b gidx=%0d oreq=%h iresps=%h, required 0/0/0/0",
                     busy, gidx, oreq, iresps);
        end
        ireqs[1] = rand_req(3);
        next_cycle();
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1234_5678};
        #1;
        checks++;
        if (busy !== 1'b1 || gidx !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_own: busy=%b gidx=%0d, required 1/1", busy, gidx);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || oreq.valid !== 1'b0 || iresps !== '0 || gidx !== 1'b0) begin
            errors++;
            $display("FAIL reset_midburst: busy=%b oreq.valid=%b iresps=%h gidx=%0d, required 0/0/0/0",
                     busy, oreq.valid, iresps, gidx);
        end
    endtask

    task automatic test_single();
        cbus_req_t req;
        logic      exp_own;
        req       = rand_req(0);
        req.write = 1'b0;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            ireqs[0]    = (t >= 5 && t <= 8) ? req : cbus_req_t'(0);
            oresp.ready = (t == 8);
            oresp.last  = (t == 8);
            oresp.data  = $urandom;
            exp_own     = (t >= 6 && t <= 8);
            #1;
            checks++;
            if (oreq.valid !== exp_own || busy !== exp_own) begin
                errors++;
                $display("FAIL single_valid_busy t=%0d: oreq.valid=%b busy=%b, required %b",
                         t, oreq.valid, busy, exp_own);
            end
            if (t == 8) begin
                checks++;
                if (iresps[0].last !== 1'b1 || iresps[0] !== oresp || oreq !== req) begin
                    errors++;
                    $display("FAIL single_last: iresps0=%h oreq=%h, required %h / %h",
                             iresps[0], oreq, oresp, req);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        cbus_req_t req0, req1;
        req0 = rand_req(3);
        req1 = rand_req(0);
        do_reset();
        for (int t = 0; t < 8; t++) begin
            ireqs[0]    = (t <= 6) ? req0 : cbus_req_t'(0);
            ireqs[1]    = req1;
            oresp.ready = (t >= 3);
            oresp.last  = (t >= 6);
            oresp.data  = $urandom;
            #1;
            if (t == 0) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_idle: busy=%b, required 0", busy);
                end
            end else if (t <= 6) begin
                checks++;
                if (gidx !== 1'b0 || oreq !== req0 || iresps[1] !== '0 || iresps[0] !== oresp) begin
                    errors++;
                    $display("FAIL contention_m0 t=%0d: gidx=%0d oreq=%h iresps=%h, required 0 / %h / {0,%h}",
                             t, gidx, oreq, iresps, req0, oresp);
                end
            end else begin
                checks++;
                if (gidx !== 1'b1 || oreq !== req1 || iresps[1] !== oresp || iresps[0] !== '0) begin
                    errors++;
                    $display("FAIL contention_m1 t=%0d: gidx=%0d oreq=%h iresps=%h, required 1 / %h / {%h,0}",
                             t, gidx, oreq, iresps, req1, oresp);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_rotation();
        int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
        do_reset();
        ireqs[0] = rand_req(0);
        ireqs[1] = rand_req(0);
        oresp    = '{ready: 1'b1, last: 1'b1, data: 32'hA5A5_0000};
        next_cycle();
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || gidx !== 1'(exp_seq[t]) || oreq !== ireqs[exp_seq[t]]) begin
                errors++;
                $display("FAIL rotation[%0d]: busy=%b gidx=%0d, required 1/%0d", t, busy, gidx, exp_seq[t]);
            end
            next_cycle();
        end
    endtask

    task automatic test_sole_repeat();
        logic exp_busy[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        ireqs[1] = rand_req(0);
        for (int t = 0; t < 5; t++) begin
            oresp.ready = (t == 2);
            oresp.last  = (t == 2);
            oresp.data  = $urandom;
            #1;
            checks++;
            if (busy !== exp_busy[t] || oreq.valid !== exp_busy[t] || (exp_busy[t] && gidx !== 1'b1)) begin
                errors++;
                $display("FAIL sole_repeat t=%0d: busy=%b oreq.valid=%b gidx=%0d, required busy=%b gidx=1",
                         t, busy, oreq.valid, gidx, exp_busy[t]);
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        int exp_seq[4] = '{0, 2, 0, 2};
        do_reset();
        ireqs3[0] = rand_req(0);
        ireqs3[2] = rand_req(0);
        oresp3    = '{ready: 1'b1, last: 1'b1, data: 32'h0BAD_F00D};
        next_cycle();
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++;
            if (busy3 !== 1'b1 || gidx3 !== 2'(exp_seq[t]) || iresps3[1] !== '0) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: busy=%b gidx=%0d iresps1=%h, required 1/%0d/0",
                         t, busy3, gidx3, iresps3[1], exp_seq[t]);
            end
            next_cycle();
        end
        // Master 2 finishes alone; pointer must wrap so master 0 beats master 1.
        do_reset();
        ireqs3[2] = rand_req(0);
        next_cycle();
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        next_cycle();
        oresp3    = '0;
        ireqs3[2] = '0;
        ireqs3[0] = rand_req(0);
        ireqs3[1] = rand_req(0);
        #1;
        checks++;
        if (busy3 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: busy=%b, required 0", busy3);
        end
        next_cycle();
        #1;
        checks++;
        if (busy3 !== 1'b1 || gidx3 !== 2'd0 || oreq3 !== ireqs3[0]) begin
            errors++;
            $display("FAIL wrap_ptr: busy=%b gidx=%0d, required 1/0", busy3, gidx3);
        end
    endtask

    task automatic test_random();
        bit         m_busy = 1'b0;
        int         m_owner = 0;
        int         m_ptr = 0;
        int         beat = 0;
        int         h;
        int         old_owner;
        bit         act[N];
        int         mlen[N];
        bit         vv[N];
        cbus_req_t  exp_oreq;
        cbus_resp_t exp_resp;
        do_reset();
        for (int i = 0; i < N; i++) begin
            act[i]  = 1'b0;
            mlen[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        act[i]   = 1'b1;
                        mlen[i]  = $urandom_range(0, 3);
                        ireqs[i] = rand_req(mlen[i]);
                    end else begin
                        ireqs[i] = '0;
                    end
                end
            end
            oresp.data  = $urandom;
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = m_busy ? (beat == mlen[m_owner]) : 1'($urandom_range(0, 1));
            #1;
            exp_oreq = m_busy ? ireqs[m_owner] : cbus_req_t'(0);
            checks++;
            if (busy !== m_busy || gidx !== 1'(m_owner)) begin
                errors++;
                $display("FAIL random_state cyc=%0d: busy=%b gidx=%0d, required %b/%0d",
                         cyc, busy, gidx, m_busy, m_owner);
            end
            checks++;
            if (oreq !== exp_oreq) begin
                errors++;
                $display("FAIL random_oreq cyc=%0d: got %h, required %h", cyc, oreq, exp_oreq);
            end
            for (int j = 0; j < N; j++) begin
                exp_resp = (m_busy && j == m_owner) ? oresp : cbus_resp_t'(0);
                checks++;
                if (iresps[j] !== exp_resp) begin
                    errors++;
                    $display("FAIL random_iresp%0d cyc=%0d: got %h, required %h", j, cyc, iresps[j], exp_resp);
                end
            end
            for (int i = 0; i < N; i++) vv[i] = ireqs[i].valid;
            if (!m_busy) begin
                h = find_from(vv, m_ptr, -1);
                if (h >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = h;
                    beat    = 0;
                end
            end else if (oresp.ready) begin
                if (oresp.last) begin
                    old_owner      = m_owner;
                    act[old_owner] = 1'b0;
                    m_ptr          = (old_owner + 1) % N;
                    h              = find_from(vv, m_ptr, old_owner);
                    if (h >= 0) begin
                        m_owner = h;
                        beat    = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    beat++;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_sole_repeat();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
